// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage. Owns the program counter, addresses a 2**AW-word
// instruction memory and captures the returned word into the IF/ID register.
// Redirects (jr > jump > branch) come back from decode, flush the wrong-path
// fetch and always win over stall. When the PC leaves instruction-memory range
// the stage parks in HALT until a redirect or reset.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   stall               : hold PC and IF/ID (ignored in HALT, loses to redirect)
//   br_taken/br_imm     : taken branch and its word offset
//   br_pc4              : PC+4 of the branch/jump in decode
//   jump/jump_index     : j/jal and its target field
//   jr/jr_target        : jr and its register value
//   imem_a / imem_rd    : instruction memory word address / read data
//   pc                  : current fetch PC
//   if_instr/if_pc4     : IF/ID instruction and PC+4
//   if_valid            : IF/ID holds a real instruction
//   halted              : FSM state, high while in HALT
//   fetch_count         : instructions accepted into IF/ID (wraps)
//
// Handshake: there is no valid/ready pair here; stall acts as the consumer's
// "not ready" and holds every register, and if_valid marks IF/ID contents as a
// real instruction. A redirect discards whatever IF/ID holds.
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int          AW       = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          br_taken,
  input  logic [15:0]   br_imm,
  input  logic [31:0]   br_pc4,
  input  logic          jump,
  input  logic [25:0]   jump_index,
  input  logic          jr,
  input  logic [31:0]   jr_target,
  output logic [AW-1:0] imem_a,
  input  logic [31:0]   imem_rd,
  output logic [31:0]   pc,
  output logic [31:0]   if_instr,
  output logic [31:0]   if_pc4,
  output logic          if_valid,
  output logic          halted,
  output logic [31:0]   fetch_count
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc4_q, if_pc4_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        in_range;

  // jr targets are word aligned by construction; the low two bits are dropped.
  logic        unused_jr_low;
  assign unused_jr_low = ^jr_target[1:0];

  assign redirect = jr | jump | br_taken;
  assign pc_plus4 = pc_q + 32'd4;
  assign in_range = (pc_q[31:AW+2] == '0);

  always_comb begin
    target = br_pc4 + {{14{br_imm[15]}}, br_imm, 2'b00};
    if (jr) begin
      target = {jr_target[31:2], 2'b00};
    end else if (jump) begin
      target = {br_pc4[31:28], jump_index, 2'b00};
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_instr_d    = if_instr_q;
    if_pc4_d      = if_pc4_q;
    if_valid_d    = if_valid_q;
    fetch_count_d = fetch_count_q;

    if (redirect) begin
      // Redirect always lands in RUN; an out-of-range target re-halts on the
      // following cycle through the normal range check.
      pc_d       = target;
      if_valid_d = 1'b0;
      state_d    = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (!stall) begin
            if (!in_range) begin
              state_d    = HALT;
              if_valid_d = 1'b0;
            end else begin
              if_instr_d    = imem_rd;
              if_pc4_d      = pc_plus4;
              if_valid_d    = 1'b1;
              pc_d          = pc_plus4;
              fetch_count_d = fetch_count_q + 32'd1;
            end
          end
        end
        HALT: begin
          if_valid_d = 1'b0;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      if_instr_q    <= '0;
      if_pc4_q      <= '0;
      if_valid_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_instr_q    <= if_instr_d;
      if_pc4_q      <= if_pc4_d;
      if_valid_q    <= if_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // imem_a only carries the low PC bits, so it always indexes inside memory.
  assign imem_a      = pc_q[AW+1:2];
  assign pc          = pc_q;
  assign if_instr    = if_instr_q;
  assign if_pc4      = if_pc4_q;
  assign if_valid    = if_valid_q;
  assign halted      = (state_q == HALT);
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage: reset, free-run, branch, stall, redirect
// priority, halt/resume and mid-stream reset. Instruction memory is a local
// array: words 0..2 hold the test program, every other word i holds
// 32'hA000_0000 + i so fetched words identify their address.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_imm;
  logic [31:0] br_pc4;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic [5:0]  imem_a;
  logic [31:0] imem_rd;
  logic [31:0] pc;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic        if_valid;
  logic        halted;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:63];

  int checks;
  int failures;

  fetch_stage #(.AW(6), .RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_imm     (br_imm),
    .br_pc4     (br_pc4),
    .jump       (jump),
    .jump_index (jump_index),
    .jr         (jr),
    .jr_target  (jr_target),
    .imem_a     (imem_a),
    .imem_rd    (imem_rd),
    .pc         (pc),
    .if_instr   (if_instr),
    .if_pc4     (if_pc4),
    .if_valid   (if_valid),
    .halted     (halted),
    .fetch_count(fetch_count)
  );

  assign imem_rd = mem[imem_a];

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    reset      = 1'b0;
    stall      = 1'b0;
    br_taken   = 1'b0;
    br_imm     = 16'h0;
    br_pc4     = 32'h0;
    jump       = 1'b0;
    jump_index = 26'h0;
    jr         = 1'b0;
    jr_target  = 32'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Reset values, then three free-running fetches of the program words.
  task automatic test_reset();
    do_reset();
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc actual=%h expected=%h", pc, 32'h0); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%b expected=0", if_valid); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted actual=%b expected=0", halted); end
    checks++; if (fetch_count !== 32'h0) begin failures++; $display("FAIL reset_count actual=%0d expected=0", fetch_count); end
    checks++; if (if_instr !== 32'h0 || if_pc4 !== 32'h0) begin failures++; $display("FAIL reset_ifid actual=%h/%h expected=0/0", if_instr, if_pc4); end
  endtask

  task automatic test_free_run();
    step();
    checks++; if (if_instr !== 32'h2001_0007 || if_pc4 !== 32'h4 || if_valid !== 1'b1) begin failures++; $display("FAIL run_c1 actual=%h/%h/%b expected=20010007/00000004/1", if_instr, if_pc4, if_valid); end
    step();
    checks++; if (if_instr !== 32'h2002_0008 || if_pc4 !== 32'h8) begin failures++; $display("FAIL run_c2 actual=%h/%h expected=20020008/00000008", if_instr, if_pc4); end
    step();
    checks++; if (if_instr !== 32'h2004_000F || if_pc4 !== 32'hC) begin failures++; $display("FAIL run_c3 actual=%h/%h expected=2004000f/0000000c", if_instr, if_pc4); end
    checks++; if (fetch_count !== 32'd3 || pc !== 32'hC) begin failures++; $display("FAIL run_count actual=%0d/%h expected=3/0000000c", fetch_count, pc); end
  endtask

  // Forward branch at 0x38 with offset +1, then a backward branch.
  task automatic test_branch();
    for (int i = 0; i < 11; i++) step();
    checks++; if (pc !== 32'h38 || fetch_count !== 32'd14) begin failures++; $display("FAIL br_setup actual=%h/%0d expected=00000038/14", pc, fetch_count); end
    br_taken = 1'b1; br_pc4 = 32'h38; br_imm = 16'h0001;
    step();
    clear_inputs();
    checks++; if (pc !== 32'h3C || if_valid !== 1'b0) begin failures++; $display("FAIL br_flush actual=%h/%b expected=0000003c/0", pc, if_valid); end
    step();
    checks++; if (if_instr !== 32'hA000_000F || if_valid !== 1'b1 || pc !== 32'h40) begin failures++; $display("FAIL br_target actual=%h/%b/%h expected=a000000f/1/00000040", if_instr, if_valid, pc); end
    checks++; if (fetch_count !== 32'd15) begin failures++; $display("FAIL br_count actual=%0d expected=15", fetch_count); end
    br_taken = 1'b1; br_pc4 = 32'h40; br_imm = 16'hFFFC;
    step();
    clear_inputs();
    checks++; if (pc !== 32'h30 || if_valid !== 1'b0) begin failures++; $display("FAIL br_back actual=%h/%b expected=00000030/0", pc, if_valid); end
  endtask

  // Reach pc=0x14 with a valid IF/ID, then stall three cycles.
  task automatic test_stall();
    jr = 1'b1; jr_target = 32'h10;
    step();
    clear_inputs();
    step();
    checks++; if (pc !== 32'h14 || if_valid !== 1'b1 || if_instr !== 32'hA000_0004 || fetch_count !== 32'd16) begin failures++; $display("FAIL stall_setup actual=%h/%b/%h/%0d expected=00000014/1/a0000004/16", pc, if_valid, if_instr, fetch_count); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pc !== 32'h14 || if_valid !== 1'b1 || if_instr !== 32'hA000_0004 || fetch_count !== 32'd16) begin failures++; $display("FAIL stall_hold%0d actual=%h/%b/%h/%0d expected=00000014/1/a0000004/16", i, pc, if_valid, if_instr, fetch_count); end
    end
    stall = 1'b0;
    step();
    checks++; if (pc !== 32'h18 || if_instr !== 32'hA000_0005 || if_pc4 !== 32'h18 || fetch_count !== 32'd17) begin failures++; $display("FAIL stall_resume actual=%h/%h/%h/%0d expected=00000018/a0000005/00000018/17", pc, if_instr, if_pc4, fetch_count); end
  endtask

  // Redirect wins over stall; jr > jump > branch.
  task automatic test_redirect_priority();
    stall = 1'b1; jr = 1'b1; jr_target = 32'h0000_0013;
    step();
    clear_inputs();
    checks++; if (pc !== 32'h10 || if_valid !== 1'b0) begin failures++; $display("FAIL stall_jr actual=%h/%b expected=00000010/0", pc, if_valid); end
    jr = 1'b1; jr_target = 32'h20; jump = 1'b1; jump_index = 26'd5; br_taken = 1'b1; br_pc4 = 32'h100; br_imm = 16'h1;
    step();
    clear_inputs();
    checks++; if (pc !== 32'h20) begin failures++; $display("FAIL prio_jr actual=%h expected=00000020", pc); end
    jump = 1'b1; jump_index = 26'd5; br_taken = 1'b1; br_pc4 = 32'h100; br_imm = 16'h1;
    step();
    clear_inputs();
    checks++; if (pc !== 32'h14) begin failures++; $display("FAIL prio_jump actual=%h expected=00000014", pc); end
    checks++; if (fetch_count !== 32'd17) begin failures++; $display("FAIL prio_count actual=%0d expected=17", fetch_count); end
  endtask

  // Run off the end of memory, sit in HALT, then jump back.
  task automatic test_halt();
    jr = 1'b1; jr_target = 32'hFC;
    step();
    clear_inputs();
    step();
    checks++; if (pc !== 32'h100 || if_instr !== 32'hA000_003F || if_valid !== 1'b1 || halted !== 1'b0) begin failures++; $display("FAIL halt_last actual=%h/%h/%b/%b expected=00000100/a000003f/1/0", pc, if_instr, if_valid, halted); end
    step();
    checks++; if (halted !== 1'b1 || if_valid !== 1'b0 || pc !== 32'h100) begin failures++; $display("FAIL halt_enter actual=%b/%b/%h expected=1/0/00000100", halted, if_valid, pc); end
    checks++; if (imem_a !== 6'd0) begin failures++; $display("FAIL halt_imem_a actual=%0d expected=0", imem_a); end
    stall = 1'b1;
    step();
    stall = 1'b0;
    step();
    checks++; if (halted !== 1'b1 || pc !== 32'h100 || fetch_count !== 32'd18) begin failures++; $display("FAIL halt_hold actual=%b/%h/%0d expected=1/00000100/18", halted, pc, fetch_count); end
    jump = 1'b1; jump_index = 26'd2; br_pc4 = 32'h100;
    step();
    clear_inputs();
    checks++; if (pc !== 32'h8 || halted !== 1'b0 || if_valid !== 1'b0) begin failures++; $display("FAIL halt_exit actual=%h/%b/%b expected=00000008/0/0", pc, halted, if_valid); end
    step();
    checks++; if (if_instr !== 32'h2004_000F || if_valid !== 1'b1 || pc !== 32'hC) begin failures++; $display("FAIL halt_resume actual=%h/%b/%h expected=2004000f/1/0000000c", if_instr, if_valid, pc); end
    // Out-of-range redirect: leaves RUN again one cycle later.
    jr = 1'b1; jr_target = 32'h200;
    step();
    clear_inputs();
    checks++; if (pc !== 32'h200 || halted !== 1'b0) begin failures++; $display("FAIL oor_target actual=%h/%b expected=00000200/0", pc, halted); end
    step();
    checks++; if (halted !== 1'b1 || pc !== 32'h200) begin failures++; $display("FAIL oor_rehalt actual=%b/%h expected=1/00000200", halted, pc); end
  endtask

  // Reset mid-stream with stall and a branch also asserted.
  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 7; i++) step();
    checks++; if (if_valid !== 1'b1 || fetch_count !== 32'd7) begin failures++; $display("FAIL mid_setup actual=%b/%0d expected=1/7", if_valid, fetch_count); end
    reset = 1'b1; stall = 1'b1; br_taken = 1'b1; br_pc4 = 32'h20; br_imm = 16'h4;
    step();
    clear_inputs();
    checks++; if (pc !== 32'h0 || if_valid !== 1'b0 || halted !== 1'b0 || fetch_count !== 32'h0 || if_instr !== 32'h0 || if_pc4 !== 32'h0) begin failures++; $display("FAIL mid_reset actual=%h/%b/%b/%0d/%h/%h expected=0/0/0/0/0/0", pc, if_valid, halted, fetch_count, if_instr, if_pc4); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
    mem[0] = 32'h2001_0007;
    mem[1] = 32'h2002_0008;
    mem[2] = 32'h2004_000F;
    clear_inputs();
    #2;
    test_reset();
    test_free_run();
    test_branch();
    test_stall();
    test_redirect_priority();
    test_halt();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
